// File: rtl/zx_key_matrix_if.sv
// Byte stream from the PS/2 receiver plus the ULA half-row read path.
// The master side drives the scan-code strobes and CPU address; the slave returns key_row.
interface zx_key_matrix_if;
  logic [7:0] scan_code;
  logic       scan_code_ready;
  logic       scan_code_error;
  logic [7:0] A;
  logic [4:0] key_row;

  modport master (
    output scan_code, scan_code_ready, scan_code_error, A,
    input  key_row
  );

  modport slave (
    input  scan_code, scan_code_ready, scan_code_error, A,
    output key_row
  );
endinterface

// File: rtl/zx_key_matrix.sv
// PS/2 set-2 scan codes to ZX Spectrum 8x5 keyboard matrix.
// key_row is purely combinational from the held-key matrix and the half-row address.
module zx_key_matrix #(
  parameter bit          CLEAR_ON_ERROR = 1'b0,
  parameter int unsigned PAUSE_SKIP     = 7
) (
  input  logic           clk,
  input  logic           reset,
  zx_key_matrix_if.slave kbd
);

  localparam int SKIP_W = (PAUSE_SKIP < 2) ? 1 : $clog2(PAUSE_SKIP + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_SKIP
  } state_e;

  typedef enum logic [2:0] {
    T_NONE,
    T_KEY,
    T_LSHIFT,
    T_RSHIFT,
    T_COMP
  } tgt_kind_e;

  // For T_COMP, col is the composite index: 0 bksp, 1 left, 2 down, 3 up, 4 right.
  typedef struct packed {
    tgt_kind_e  kind;
    logic [2:0] row;
    logic [2:0] col;
  } key_tgt_t;

  function automatic key_tgt_t key_at(input logic [2:0] r, input logic [2:0] c);
    key_tgt_t t;
    t.kind = T_KEY;
    t.row  = r;
    t.col  = c;
    return t;
  endfunction

  function automatic key_tgt_t special(input tgt_kind_e k, input logic [2:0] c);
    key_tgt_t t;
    t.kind = k;
    t.row  = 3'd0;
    t.col  = c;
    return t;
  endfunction

  function automatic key_tgt_t map_normal(input logic [7:0] code);
    key_tgt_t t;
    t = special(T_NONE, 3'd0);
    case (code)
      8'h12: t = special(T_LSHIFT, 3'd0);
      8'h59: t = special(T_RSHIFT, 3'd0);
      8'h66: t = special(T_COMP, 3'd0);
      8'h1A: t = key_at(3'd0, 3'd1);
      8'h22: t = key_at(3'd0, 3'd2);
      8'h21: t = key_at(3'd0, 3'd3);
      8'h2A: t = key_at(3'd0, 3'd4);
      8'h1C: t = key_at(3'd1, 3'd0);
      8'h1B: t = key_at(3'd1, 3'd1);
      8'h23: t = key_at(3'd1, 3'd2);
      8'h2B: t = key_at(3'd1, 3'd3);
      8'h34: t = key_at(3'd1, 3'd4);
      8'h15: t = key_at(3'd2, 3'd0);
      8'h1D: t = key_at(3'd2, 3'd1);
      8'h24: t = key_at(3'd2, 3'd2);
      8'h2D: t = key_at(3'd2, 3'd3);
      8'h2C: t = key_at(3'd2, 3'd4);
      8'h16: t = key_at(3'd3, 3'd0);
      8'h1E: t = key_at(3'd3, 3'd1);
      8'h26: t = key_at(3'd3, 3'd2);
      8'h25: t = key_at(3'd3, 3'd3);
      8'h2E: t = key_at(3'd3, 3'd4);
      8'h45: t = key_at(3'd4, 3'd0);
      8'h46: t = key_at(3'd4, 3'd1);
      8'h3E: t = key_at(3'd4, 3'd2);
      8'h3D: t = key_at(3'd4, 3'd3);
      8'h36: t = key_at(3'd4, 3'd4);
      8'h4D: t = key_at(3'd5, 3'd0);
      8'h44: t = key_at(3'd5, 3'd1);
      8'h43: t = key_at(3'd5, 3'd2);
      8'h3C: t = key_at(3'd5, 3'd3);
      8'h35: t = key_at(3'd5, 3'd4);
      8'h5A: t = key_at(3'd6, 3'd0);
      8'h4B: t = key_at(3'd6, 3'd1);
      8'h42: t = key_at(3'd6, 3'd2);
      8'h3B: t = key_at(3'd6, 3'd3);
      8'h33: t = key_at(3'd6, 3'd4);
      8'h29: t = key_at(3'd7, 3'd0);
      8'h14: t = key_at(3'd7, 3'd1);
      8'h3A: t = key_at(3'd7, 3'd2);
      8'h31: t = key_at(3'd7, 3'd3);
      8'h32: t = key_at(3'd7, 3'd4);
      default: t = special(T_NONE, 3'd0);
    endcase
    return t;
  endfunction

  // E0 12 (fake shift) and every other unlisted extended code fall through to T_NONE.
  function automatic key_tgt_t map_ext(input logic [7:0] code);
    key_tgt_t t;
    case (code)
      8'h14:   t = key_at(3'd7, 3'd1);
      8'h6B:   t = special(T_COMP, 3'd1);
      8'h72:   t = special(T_COMP, 3'd2);
      8'h75:   t = special(T_COMP, 3'd3);
      8'h74:   t = special(T_COMP, 3'd4);
      default: t = special(T_NONE, 3'd0);
    endcase
    return t;
  endfunction

  state_e            state_q, state_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic              do_press, do_release, use_ext, clear_all;
  key_tgt_t          tgt;

  logic [7:0][4:0] phys_q;
  logic            lshift_q, rshift_q;
  logic [4:0]      comp_q;
  logic [7:0][4:0] eff;
  logic [4:0]      key_row_c;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    skip_d     = skip_q;
    do_press   = 1'b0;
    do_release = 1'b0;
    use_ext    = 1'b0;
    clear_all  = 1'b0;
    if (kbd.scan_code_error) begin
      state_d   = S_IDLE;
      skip_d    = '0;
      clear_all = CLEAR_ON_ERROR;
    end else if (kbd.scan_code_ready) begin
      case (state_q)
        S_IDLE: begin
          case (kbd.scan_code)
            8'hE0: state_d = S_EXT;
            8'hF0: state_d = S_BRK;
            8'hE1: begin
              if (PAUSE_SKIP != 0) begin
                state_d = S_SKIP;
                skip_d  = SKIP_W'(PAUSE_SKIP);
              end
            end
            8'hAA:   clear_all = 1'b1;
            default: do_press  = 1'b1;
          endcase
        end
        S_EXT: begin
          if (kbd.scan_code == 8'hF0) begin
            state_d = S_EXT_BRK;
          end else begin
            do_press = 1'b1;
            use_ext  = 1'b1;
            state_d  = S_IDLE;
          end
        end
        S_BRK: begin
          do_release = 1'b1;
          state_d    = S_IDLE;
        end
        S_EXT_BRK: begin
          do_release = 1'b1;
          use_ext    = 1'b1;
          state_d    = S_IDLE;
        end
        S_SKIP: begin
          if (skip_q <= SKIP_W'(1)) begin
            skip_d  = '0;
            state_d = S_IDLE;
          end else begin
            skip_d = skip_q - SKIP_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign tgt = use_ext ? map_ext(kbd.scan_code) : map_normal(kbd.scan_code);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  // NOTE: the 40-bit matrix is plain flops, not a RAM, so it takes the async reset like any other state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phys_q   <= '0;
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
      comp_q   <= '0;
    end else if (clear_all) begin
      phys_q   <= '0;
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
      comp_q   <= '0;
    end else if (do_press || do_release) begin
      case (tgt.kind)
        T_KEY:    phys_q[tgt.row][tgt.col] <= do_press;
        T_LSHIFT: lshift_q                 <= do_press;
        T_RSHIFT: rshift_q                 <= do_press;
        T_COMP:   comp_q[tgt.col]          <= do_press;
        default:  ;
      endcase
    end
  end

  // Composite keys OR into CS and their digit without touching the physical bits.
  always_comb begin
    eff       = phys_q;
    eff[0][0] = lshift_q | rshift_q | (|comp_q);
    eff[4][0] = phys_q[4][0] | comp_q[0];
    eff[3][4] = phys_q[3][4] | comp_q[1];
    eff[4][4] = phys_q[4][4] | comp_q[2];
    eff[4][3] = phys_q[4][3] | comp_q[3];
    eff[4][2] = phys_q[4][2] | comp_q[4];
  end

  always_comb begin
    key_row_c = '1;
    for (int r = 0; r < 8; r++) begin
      if (!kbd.A[r]) key_row_c = key_row_c & ~eff[r];
    end
  end

  assign kbd.key_row = key_row_c;

endmodule

// File: doc/zx_key_matrix.md
Name: zx_key_matrix

Overview:
- Converts the PS/2 set-2 scan-code stream into the 8x5 ZX Spectrum keyboard matrix.
- Sits between the PS/2 byte receiver (scan_code / scan_code_ready / scan_code_error) and the ULA I/O read path.
- Returns key_row[4:0] for the half-rows selected by the high address byte of an IN from port FE.
- Tracks make/break (F0) and extended (E0) prefixes, and maps arrow keys and Backspace to CAPS SHIFT combinations.

Parameters:
CLEAR_ON_ERROR, 0, when 1 a scan_code_error pulse also releases every key in the matrix.
PAUSE_SKIP, 7, number of bytes discarded after an E1 prefix (Pause key sequence).

Ports:
clk  input  1  system clock, the CPU clock domain (3.5 MHz); all state on rising edge
reset  input  1  asynchronous, active-low reset
scan_code  input  8  received PS/2 byte, valid while scan_code_ready=1
scan_code_ready  input  1  one-cycle strobe: scan_code holds a new byte
scan_code_error  input  1  one-cycle strobe: framing/parity error on the PS/2 receiver
A  input  8  CPU address bits 15:8 (half-row select, active-low)
key_row  output  5  active-low key state; 0 = pressed

Behaviour:
- Reset (reset=0, asynchronous): all 40 matrix bits released, composite flags cleared, FSM=IDLE, skip counter=0. key_row then reads 5'b11111.
- Matrix layout, row:A-bit, keys bit0..bit4:
  - r0:A8 CS Z X C V
  - r1:A9 A S D F G
  - r2:A10 Q W E R T
  - r3:A11 1 2 3 4 5
  - r4:A12 0 9 8 7 6
  - r5:A13 P O I U Y
  - r6:A14 ENTER L K J H
  - r7:A15 SPACE SS M N B
- Set-2 code map, same order:
  - r0: 12/59, 1A, 22, 21, 2A
  - r1: 1C, 1B, 23, 2B, 34
  - r2: 15, 1D, 24, 2D, 2C
  - r3: 16, 1E, 26, 25, 2E
  - r4: 45, 46, 3E, 3D, 36
  - r5: 4D, 44, 43, 3C, 35
  - r6: 5A, 4B, 42, 3B, 33
  - r7: 29, 14 (L-Ctrl; E0 14 R-Ctrl also), 3A, 31, 32
- Left and right Shift are tracked as separate flags.
- Composite keys, each with its own held flag; each also asserts a digit:
  - Backspace 66 = CS+0
  - E0 6B left = CS+5
  - E0 72 down = CS+6
  - E0 75 up = CS+7
  - E0 74 right = CS+8
- Effective CS = lshift | rshift | any composite flag.
- Effective digit bit = its physical bit | its composite flag(s).
- Releasing a composite key never releases a physically held Shift or digit.
- FSM states, evaluated only on cycles with scan_code_ready=1:
  - IDLE: E0 -> EXT; F0 -> BRK; E1 -> SKIP (counter=PAUSE_SKIP); AA (BAT) -> release all, stay IDLE; other byte -> press mapped key, stay IDLE.
  - EXT: F0 -> EXT_BRK; other byte -> press extended mapping -> IDLE.
  - BRK: byte -> release normal mapping -> IDLE.
  - EXT_BRK: byte -> release extended mapping -> IDLE.
  - SKIP: decrement the counter on each byte; at 1 -> IDLE. No matrix change.
- Unmapped codes (including E0 12 fake-shift) make no matrix change; the prefix is still consumed and the FSM returns to IDLE.
- Repeated make codes (typematic repeat) are idempotent.
- scan_code_error has priority over a simultaneous ready strobe:
  - FSM -> IDLE, skip counter cleared, the byte is discarded.
  - Matrix is held, or fully released if CLEAR_ON_ERROR=1.
- Latency: the matrix register updates on the clk edge sampling the strobe. key_row reflects it from the following cycle.
- key_row is combinational from the matrix and A. For each bit: key_row[b] = AND over rows r with A[8+r]=0 of ~key[r][b].
  - Multiple zero address bits select multiple rows; their pressed keys combine.
  - A=FF returns 11111.
- No output glitch depends on clk; A may change at any time.

Test Plan:
- After reset, A=FE -> key_row=11111. Send 1C -> A=FD gives 11110, A=FE still gives 11111. Send F0,1C -> A=FD gives 11111.
- Send 12 (hold L-Shift), then E0,6B, then E0,F0,6B -> A=FE bit0=0 and A=F7 bit4=0 during the arrow; after release A=F7=11111 and A=FE bit0 stays 0 until F0,12.
- Press Q (15) and 1 (16); A=F3 -> 11110; A=FB -> 11110; release Q -> A=F3 still 11110.
- Send F0 then assert scan_code_error, then 1C -> A press of A registers (FD -> 11110), proving BRK was dropped. Repeat with CLEAR_ON_ERROR=1 and Q held -> Q released on error.
- Send E1 14 77 E1 F0 14 F0 77, then 29 -> no matrix change during the Pause sequence; then A=7F -> 11110.
- Hold several keys, then send AA -> all rows 11111. Hold keys, pulse reset=0 mid-sequence after F0 -> all released, next byte 1C treated as a make.
